rdm_ring_reader: RTL and testbench
==================================

RDM_RING_READER -- requirements
Module: rdm_ring_reader

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 6, meaning bits per soft sample.
REQ-002 SHALL have parameter LANES, default 16, meaning samples per buffer word and per output beat.
REQ-003 SHALL have parameter ADDR_W, default 12, meaning buffer word-address width.
REQ-004 SHALL have parameter LEN_W, default 16, meaning width of all sample-count and offset inputs.
REQ-005 i_core_clk  in  1  sole clock; all logic rising-edge.
REQ-006 i_rx_rst  in  1  reset, synchronous, active-high.
REQ-007 i_start  in  1  single-cycle job start; accepted only in IDLE, ignored elsewhere.
REQ-008 i_e_size  in  LEN_W  circular-buffer length E in samples; sampled at accepted start.
REQ-009 i_ncb_size  in  LEN_W  samples to emit N; sampled at accepted start.
REQ-010 i_k0  in  LEN_W  start offset k0 in samples; sampled at accepted start.
REQ-011 o_rd_addr  out  ADDR_W  buffer word address.
REQ-012 o_rd_en  out  1  buffer read strobe.
REQ-013 i_rd_data  in  LANES*SAMPLE_W  read data, valid exactly 1 cycle after o_rd_en; lane 0 in LSBs.
REQ-014 o_data  out  LANES*SAMPLE_W  output samples; lane 0 in LSBs; unused lanes zero.
REQ-015 o_keep  out  LANES  per-lane valid mask, contiguous from lane 0.
REQ-016 o_valid  out  1  beat valid.
REQ-017 i_ready  in  1  downstream accept; beat transfers when o_valid and i_ready are both high.
REQ-018 o_last  out  1  marks the final beat of a job.
REQ-019 o_busy  out  1  high whenever the state is not IDLE.
REQ-020 o_err  out  1  one-cycle pulse on rejected job.

Function
REQ-021 SHALL emit, in order, samples at buffer positions (k0+n) mod E for n=0..N-1; buffer sample p resides at word p/LANES, lane p mod LANES.
REQ-022 Buffer words SHALL be 0..ceil(E/LANES)-1; the final word SHALL contribute only ((E-1) mod LANES)+1 samples, with remaining lanes discarded.
REQ-023 SHALL pack exactly LANES samples per beat, except the last beat, which SHALL carry ((N-1) mod LANES)+1 samples; o_keep SHALL mark these lanes.
REQ-024 States SHALL be IDLE, PREFETCH, STREAM, DONE. IDLE->PREFETCH on accepted start. PREFETCH->STREAM once the internal sample store holds at least min(LANES, remaining) samples. STREAM->DONE on an o_last transfer. DONE->IDLE after exactly 1 cycle.
REQ-025 First fetch SHALL read word k0/LANES and drop lanes below k0 mod LANES; later fetches SHALL advance one word at a time, wrapping from the final word to word 0; wrap SHALL be repeatable any number of times (N > E).
REQ-026 SHALL use an internal sample store of 3*LANES samples; o_rd_en SHALL be issued only when free space, counting reads in flight, is at least LANES; o_rd_en SHALL never issue after the total requested samples reach N.
REQ-027 With i_ready held high, STREAM SHALL deliver one beat per cycle except for at most one bubble per buffer wrap; first o_valid SHALL appear no later than 4 cycles after the accepted start.
REQ-028 Backpressure: while o_valid is high and i_ready is low, o_data, o_keep and o_last SHALL be held stable; no sample SHALL be lost or duplicated.
REQ-029 If E=0 or k0>=E, SHALL pulse o_err, remain in IDLE, and issue no reads.
REQ-030 N=0 SHALL transition IDLE->DONE->IDLE with no reads and no beats.
REQ-031 Position arithmetic SHALL use LEN_W+1 bits so that k0+LANES does not overflow before the mod-E wrap.
REQ-032 A start asserted in the same cycle as the DONE->IDLE transition SHALL be ignored.

Reset
REQ-033 When i_rx_rst is high at a clock edge: state=IDLE, store emptied, in-flight read data discarded, and o_valid, o_last, o_rd_en, o_busy, o_err = 0; o_rd_addr, o_data, o_keep = 0.
REQ-034 Reset mid-job SHALL abort it with no further beats; a start on the first cycle after reset release SHALL be accepted.

Verification
REQ-035 LANES=16, E=64, k0=0, N=64, i_ready=1 -> 4 full beats carrying samples 0..63, o_last on beat 4, one beat per cycle.
REQ-036 E=40, k0=30, N=50 -> sample order 30..39,0..39; beats of 16,16,16,2 samples; last o_keep=0x0003.
REQ-037 E=20, k0=5, N=100 (multiple wraps) -> stream equals (5+n) mod 20; no lost or duplicated samples.
REQ-038 Random i_ready at 30% duty on the 036 job -> identical sample sequence; outputs stable during every stall.
REQ-039 E=0, and separately k0=E=32 -> o_err pulse, o_rd_en never asserted, o_busy stays 0.
REQ-040 i_rx_rst asserted during STREAM of the 037 job -> all outputs 0 next cycle; fresh job E=16, k0=0, N=16 -> single beat, o_keep=0xFFFF, o_last=1.

Source files
------------

// File: rtl/rdm_ring_reader.sv
// Circular-buffer rate-matching reader: streams N soft samples from a ring
// of E samples starting at offset k0, packed LANES samples per output beat.
// Ports:
//   i_core_clk, i_rx_rst             clock, sync active-high reset
//   i_start, i_e_size, i_ncb_size,   job start and its parameters
//   i_k0
//   o_rd_addr, o_rd_en, i_rd_data    buffer read port, 1-cycle latency
//   o_data, o_keep, o_valid,         output beats, valid/ready handshake
//   i_ready, o_last
//   o_busy, o_err                    status; err pulses on a rejected job
// LANES must be a power of two, at least 2.
module rdm_ring_reader #(
  parameter int SAMPLE_W = 6,
  parameter int LANES    = 16,
  parameter int ADDR_W   = 12,
  parameter int LEN_W    = 16
) (
  input  logic                         i_core_clk,
  input  logic                         i_rx_rst,
  input  logic                         i_start,
  input  logic [LEN_W-1:0]             i_e_size,
  input  logic [LEN_W-1:0]             i_ncb_size,
  input  logic [LEN_W-1:0]             i_k0,
  output logic [ADDR_W-1:0]            o_rd_addr,
  output logic                         o_rd_en,
  input  logic [LANES*SAMPLE_W-1:0]    i_rd_data,
  output logic [LANES*SAMPLE_W-1:0]    o_data,
  output logic [LANES-1:0]             o_keep,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int LB = $clog2(LANES);
  localparam int CW = $clog2(3*LANES+1);
  localparam int DW = LANES*SAMPLE_W;
  localparam int SD = 3*DW;
  localparam logic [LB:0] LFULL = (LB+1)'(LANES);

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    DONE
  } state_t;

  state_t state, state_n;

  logic [LEN_W-1:0]  n_tot, rem, req;
  logic [ADDR_W-1:0] waddr, last_w;
  logic [LB:0]       last_n;
  logic [SD-1:0]     st, st_n, ins;
  logic [CW-1:0]     cnt, cnt_n, cnt_pop;
  logic [CW:0]       occ;
  logic              pend;
  logic [LB-1:0]     pend_lo;
  logic [LB:0]       pend_n;
  logic              err;

  logic              idle, bad, acc, go;
  logic [LEN_W-1:0]  em1, f_left, f_req;
  logic [ADDR_W-1:0] f_addr, f_last_w, f_next;
  logic [LB:0]       f_last_n, f_top, avail, give;
  logic [LB:0]       need, pop_n;
  logic [LB-1:0]     f_lo;
  logic              room, issue, valid, fire;

  assign idle = state == IDLE;
  assign bad  = (i_e_size == '0) || (i_k0 >= i_e_size);
  assign acc  = idle && i_start;
  assign go   = acc && !bad && (i_ncb_size != '0);
  assign em1  = i_e_size - LEN_W'(1);

  // In IDLE the first read is steered straight from the job inputs,
  // so fetching begins in the very cycle the job is accepted.
  assign f_addr   = idle ? ADDR_W'(i_k0 >> LB) : waddr;
  assign f_last_w = idle ? ADDR_W'(em1 >> LB) : last_w;
  assign f_last_n = idle ? {1'b0, em1[LB-1:0]} + (LB+1)'(1)
                         : last_n;
  assign f_lo     = idle ? i_k0[LB-1:0] : '0;
  assign f_req    = idle ? '0 : req;
  assign f_left   = idle ? i_ncb_size : n_tot - req;
  assign f_top    = (f_addr == f_last_w) ? f_last_n : LFULL;
  assign avail    = f_top - {1'b0, f_lo};
  assign give     = (f_left < LEN_W'(avail)) ? f_left[LB:0] : avail;
  assign f_next   = (f_addr == f_last_w) ? '0
                                         : f_addr + ADDR_W'(1);

  assign need    = (rem < LEN_W'(LANES)) ? rem[LB:0] : LFULL;
  assign valid   = (state == STREAM) && (cnt >= CW'(need));
  assign fire    = valid && i_ready;
  assign pop_n   = fire ? need : '0;
  assign cnt_pop = cnt - CW'(pop_n);

  // A read is only launched if the store can absorb a full word on top
  // of whatever is still in flight.
  assign occ  = {1'b0, cnt_pop} + (pend ? (CW+1)'(LANES) : '0);
  assign room = occ <= (CW+1)'(2*LANES);

  assign issue = !i_rx_rst && (go ||
                 ((state == PREFETCH || state == STREAM) &&
                  (req < n_tot) && room));

  // Returning word: drop lanes below pend_lo, keep pend_n samples.
  assign ins = (SD'(i_rd_data) >> (int'(pend_lo) * SAMPLE_W)) &
               ~({SD{1'b1}} << (int'(pend_n) * SAMPLE_W));

  // Store is a packed FIFO: head at the LSBs, bits above cnt always 0.
  always_comb begin
    st_n  = st >> (int'(pop_n) * SAMPLE_W);
    cnt_n = cnt_pop;
    if (pend) begin
      st_n  = st_n | (ins << (int'(cnt_pop) * SAMPLE_W));
      cnt_n = cnt_pop + CW'(pend_n);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (acc && !bad)
          state_n = (i_ncb_size == '0) ? DONE : PREFETCH;
      end
      PREFETCH: begin
        if (cnt_n >= CW'(need))
          state_n = STREAM;
      end
      STREAM: begin
        if (fire && o_last)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_keep = '0;
    o_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid && i < int'(need)) begin
        o_keep[i] = 1'b1;
        o_data[i*SAMPLE_W +: SAMPLE_W] = st[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  assign o_valid   = valid;
  assign o_last    = valid && (rem <= LEN_W'(LANES));
  assign o_busy    = !idle;
  assign o_err     = err;
  assign o_rd_en   = issue;
  assign o_rd_addr = issue ? f_addr : '0;

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state   <= IDLE;
      err     <= 1'b0;
      st      <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      pend_lo <= '0;
      pend_n  <= '0;
      req     <= '0;
      waddr   <= '0;
      n_tot   <= '0;
      rem     <= '0;
      last_w  <= '0;
      last_n  <= '0;
    end else begin
      state <= state_n;
      err   <= acc && bad;
      st    <= st_n;
      cnt   <= cnt_n;
      pend  <= issue;
      if (issue) begin
        pend_lo <= f_lo;
        pend_n  <= give;
        req     <= f_req + LEN_W'(give);
        waddr   <= f_next;
      end
      if (acc && !bad) begin
        n_tot  <= i_ncb_size;
        rem    <= i_ncb_size;
        last_w <= f_last_w;
        last_n <= f_last_n;
      end
      if (fire)
        rem <= rem - LEN_W'(need);
    end
  end

endmodule

// File: tb/tb_rdm_ring_reader.sv
// Scoreboard bench for rdm_ring_reader: jobs push expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_rdm_ring_reader;

  localparam int SW = 6;
  localparam int L  = 16;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int DW = SW*L;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [LW-1:0] e_size, ncb, k0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data, data;
  logic [L-1:0]  keep;
  logic          valid, ready, last, busy, err;

  always #5 clk = ~clk;

  rdm_ring_reader #(
    .SAMPLE_W(SW), .LANES(L), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .i_core_clk(clk),
    .i_rx_rst(rst),
    .i_start(start),
    .i_e_size(e_size),
    .i_ncb_size(ncb),
    .i_k0(k0),
    .o_rd_addr(rd_addr),
    .o_rd_en(rd_en),
    .i_rd_data(rd_data),
    .o_data(data),
    .o_keep(keep),
    .o_valid(valid),
    .i_ready(ready),
    .o_last(last),
    .o_busy(busy),
    .o_err(err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [L-1:0]  k;
    logic          l;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt, err_cnt, busy_cnt, xfer_cnt;
  int first_xfer, last_xfer, first_valid;
  int cur_e = 0;
  bit rnd = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] mk_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    int p;
    w = '0;
    for (int l = 0; l < L; l++) begin
      p = int'(a) * L + l;
      w[l*SW +: SW] = (p < cur_e) ? SW'(p % 64) : SW'(63);
    end
    return w;
  endfunction

  // Buffer model: data valid exactly one cycle after rd_en.
  always @(posedge clk)
    rd_data <= rd_en ? mk_word(rd_addr) : '1;

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  beat_t hold, exp_b;
  bit stalled = 1'b0;

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (err) err_cnt++;
    if (busy) busy_cnt++;
    if (valid && first_valid < 0) first_valid = cyc;
    if (stalled) begin
      checks++;
      if (!valid || data !== hold.d || keep !== hold.k ||
          last !== hold.l) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b d=%h k=%h l=%0b want v=1 d=%h k=%h l=%0b",
                 valid, data, keep, last, hold.d, hold.k, hold.l);
      end
    end
    stalled = valid && !ready;
    hold = {data, keep, last};
    if (valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got d=%h k=%h l=%0b want none",
                 data, keep, last);
      end else begin
        exp_b = sb.pop_front();
        if (data !== exp_b.d || keep !== exp_b.k || last !== exp_b.l) begin
          errors++;
          $display("FAIL beat: got d=%h k=%h l=%0b want d=%h k=%h l=%0b",
                   data, keep, last, exp_b.d, exp_b.k, exp_b.l);
        end
      end
      if (xfer_cnt == 0) first_xfer = cyc;
      last_xfer = cyc;
      xfer_cnt++;
    end
  end

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_job(input int e, input int k, input int n);
    beat_t b;
    int lane;
    if (e == 0 || k >= e) return;
    b = '0;
    for (int i = 0; i < n; i++) begin
      lane = i % L;
      b.d[lane*SW +: SW] = SW'(((k + i) % e) % 64);
      b.k[lane] = 1'b1;
      if (lane == L-1 || i == n-1) begin
        b.l = (i == n-1);
        sb.push_back(b);
        b = '0;
      end
    end
  endtask

  task automatic pulse_start(input int e, input int k, input int n);
    cur_e = e;
    e_size = LW'(e);
    k0 = LW'(k);
    ncb = LW'(n);
    rd_cnt = 0;
    err_cnt = 0;
    busy_cnt = 0;
    xfer_cnt = 0;
    first_valid = -1;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still high after 2000 cycles",
               name);
    end
    @(posedge clk);
    #1;
    chk({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic run_job(input string name, input int e, input int k,
                         input int n);
    push_job(e, k, n);
    pulse_start(e, k, n);
    wait_idle(name);
  endtask

  initial begin
    int i;
    rst = 1'b1;
    start = 1'b0;
    e_size = '0;
    ncb = '0;
    k0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data", data, 0);
    chk("rst_keep", keep, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_job("j035", 64, 0, 64);
    chk("j035_beats", xfer_cnt, 4);
    chk("j035_reads", rd_cnt, 4);
    chk("j035_b2b", last_xfer - first_xfer, 3);
    chk("j035_lat", (first_valid - t0) <= 4, 1);

    run_job("j036", 40, 30, 50);
    chk("j036_beats", xfer_cnt, 4);
    chk("j036_reads", rd_cnt, 5);
    chk("j036_lat", (first_valid - t0) <= 4, 1);

    rnd = 1'b1;
    run_job("j038", 40, 30, 50);
    rnd = 1'b0;
    chk("j038_beats", xfer_cnt, 4);

    run_job("j037", 20, 5, 100);
    chk("j037_beats", xfer_cnt, 7);
    chk("j037_lat", (first_valid - t0) <= 4, 1);

    run_job("e0", 0, 0, 10);
    chk("e0_err", err_cnt, 1);
    chk("e0_reads", rd_cnt, 0);
    chk("e0_busy", busy_cnt, 0);

    run_job("k0e", 32, 32, 10);
    chk("k0e_err", err_cnt, 1);
    chk("k0e_reads", rd_cnt, 0);
    chk("k0e_busy", busy_cnt, 0);

    run_job("n0", 16, 0, 0);
    chk("n0_beats", xfer_cnt, 0);
    chk("n0_reads", rd_cnt, 0);
    chk("n0_busy", busy_cnt, 1);

    // Start held into the DONE cycle with a real job: must be ignored.
    pulse_start(16, 0, 0);
    ncb = LW'(16);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("done_start");
    chk("done_start_beats", xfer_cnt, 0);
    chk("done_start_reads", rd_cnt, 0);
    chk("done_start_busy", busy_cnt, 1);

    push_job(20, 5, 100);
    pulse_start(20, 5, 100);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    chk("j040_stream", valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    sb.delete();
    chk("j040_valid", valid, 0);
    chk("j040_last", last, 0);
    chk("j040_rd_en", rd_en, 0);
    chk("j040_busy", busy, 0);
    chk("j040_err", err, 0);
    chk("j040_addr", rd_addr, 0);
    chk("j040_data", data, 0);
    chk("j040_keep", keep, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_job("j040b", 16, 0, 16);
    chk("j040b_beats", xfer_cnt, 1);
    chk("j040b_reads", rd_cnt, 1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
